vc_drop_unit: RTL and testbench

VC_DROP_UNIT -- requirements
Module: vc_DropUnit

---
 rtl/vc_drop_unit.sv | 107 ++++++++++
 tb/tb_vc_drop_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vc_drop_unit.sv
// Memory-response drop unit: after a pipeline squash it silently consumes the responses of
// requests already in flight. Optional drop statistics counter enabled by VC_DROP_UNIT_STATS_EN.
module vc_drop_unit #(
  parameter int p_msg_nbits = 32,
  parameter int p_max_out   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       domain,
  input  logic                       req_issue,
  output logic                       req_rdy,
  input  logic                       squash,
  input  logic                       in_resp_val,
  output logic                       in_resp_rdy,
  input  logic [p_msg_nbits-1:0]     in_resp_msg,
  output logic                       out_resp_val,
  input  logic                       out_resp_rdy,
  output logic [p_msg_nbits-1:0]     out_resp_msg,
  output logic [$clog2(p_max_out):0] num_out
`ifdef VC_DROP_UNIT_STATS_EN
  ,
  output logic [15:0]                num_dropped
`endif
);

  localparam int CW = $clog2(p_max_out) + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(p_max_out);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {PASS, DROP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          issue_ok;
  logic          accept;
  logic          acc_ok;
  logic [CW-1:0] issue_inc;
  logic [CW-1:0] acc_dec;

  // The domain input is a security label for the information-flow checker; no logic depends on it.
  logic unused_domain;
  assign unused_domain = domain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PASS;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    drop_d       = drop_q;
    req_rdy      = (out_q < MAX_OUT);
    out_resp_val = in_resp_val;
    in_resp_rdy  = out_resp_rdy;
    out_resp_msg = in_resp_msg;

    if (state_q == DROP) begin
      out_resp_val = 1'b0;
      in_resp_rdy  = 1'b1;
      out_resp_msg = '0;
    end

    issue_ok  = req_issue && req_rdy;
    accept    = in_resp_val && in_resp_rdy;
    // A response with nothing outstanding is a protocol error and must not underflow the counts.
    acc_ok    = accept && (out_q != '0);
    issue_inc = {{(CW-1){1'b0}}, issue_ok};
    acc_dec   = {{(CW-1){1'b0}}, acc_ok};

    out_d = out_q + issue_inc - acc_dec;

    // A squash drops everything older than this cycle; a same-cycle issue is on the new path.
    if (squash) begin
      drop_d = out_q - acc_dec;
    end else if ((state_q == DROP) && acc_ok) begin
      drop_d = drop_q - ONE;
    end

    state_d = (drop_d != '0) ? DROP : PASS;
  end

  assign num_out = out_q;

`ifdef VC_DROP_UNIT_STATS_EN
  logic [15:0] dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= '0;
    end else if ((state_q == DROP) && acc_ok && (dropped_q != 16'hFFFF)) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  assign num_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_vc_drop_unit.sv
// Scoreboard bench for vc_drop_unit: directed scenarios followed by a random phase.
// Build with VC_DROP_UNIT_STATS_EN defined to also exercise the drop statistics counter.
module tb_vc_drop_unit;

  localparam int MSG_W = 32;
  localparam int MAXO  = 4;

  logic             clk;
  logic             reset;
  logic             domain;
  logic             req_issue;
  logic             req_rdy;
  logic             squash;
  logic             in_resp_val;
  logic             in_resp_rdy;
  logic [MSG_W-1:0] in_resp_msg;
  logic             out_resp_val;
  logic             out_resp_rdy;
  logic [MSG_W-1:0] out_resp_msg;
  logic [2:0]       num_out;
`ifdef VC_DROP_UNIT_STATS_EN
  logic [15:0]      num_dropped;
`endif

  vc_drop_unit #(.p_msg_nbits(MSG_W), .p_max_out(MAXO)) dut (
    .clk          (clk),
    .reset        (reset),
    .domain       (domain),
    .req_issue    (req_issue),
    .req_rdy      (req_rdy),
    .squash       (squash),
    .in_resp_val  (in_resp_val),
    .in_resp_rdy  (in_resp_rdy),
    .in_resp_msg  (in_resp_msg),
    .out_resp_val (out_resp_val),
    .out_resp_rdy (out_resp_rdy),
    .out_resp_msg (out_resp_msg),
    .num_out      (num_out)
`ifdef VC_DROP_UNIT_STATS_EN
    ,
    .num_dropped  (num_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [MSG_W-1:0] sb[$];
  int mO = 0;
  int mD = 0;
  int mDropped = 0;
  logic [MSG_W-1:0] msg_ctr = 32'hA000_0000;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus (entered #1 after a rising edge), check, then advance the model.
  task automatic cycle(input logic iss, input logic sq, input logic rv, input logic ordy);
    logic pass, exp_orv, exp_irdy, acc_ok, iss_ok;
    logic [MSG_W-1:0] msg;
    msg_ctr = msg_ctr + 32'h1;
    msg = msg_ctr;
    req_issue = iss; squash = sq; in_resp_val = rv; out_resp_rdy = ordy; in_resp_msg = msg;
    pass     = (mD == 0);
    exp_orv  = pass && rv;
    exp_irdy = pass ? ordy : 1'b1;
    acc_ok   = rv && exp_irdy && (mO != 0);
    iss_ok   = iss && (mO < MAXO);
    if (exp_orv && ordy) sb.push_back(msg);
    #2;
    check_eq("req_rdy", {31'b0, req_rdy}, {31'b0, (mO < MAXO)});
    check_eq("num_out", {29'b0, num_out}, mO);
    check_eq("in_resp_rdy", {31'b0, in_resp_rdy}, {31'b0, exp_irdy});
    check_eq("out_resp_val", {31'b0, out_resp_val}, {31'b0, exp_orv});
    if (!pass) check_eq("drop_msg_zero", out_resp_msg, 32'h0);
    if (out_resp_val && out_resp_rdy && (sb.size() > 0)) check_eq("sb_msg", out_resp_msg, sb.pop_front());
`ifdef VC_DROP_UNIT_STATS_EN
    check_eq("num_dropped", {16'b0, num_dropped}, mDropped);
`endif
    if (!pass && acc_ok && mDropped < 65535) mDropped++;
    if (sq) mD = mO - int'(acc_ok);
    else if (!pass && acc_ok) mD = mD - 1;
    mO = mO + int'(iss_ok) - int'(acc_ok);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_resp_val = 1'b1; out_resp_rdy = 1'b0;
    #1;
    check_eq("rst_num_out", {29'b0, num_out}, 32'd0);
    check_eq("rst_req_rdy", {31'b0, req_rdy}, 32'd1);
    check_eq("rst_out_val", {31'b0, out_resp_val}, 32'd1);
    check_eq("rst_in_rdy", {31'b0, in_resp_rdy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_resp_val = 1'b0; out_resp_rdy = 1'b1;
    mO = 0; mD = 0; mDropped = 0;
  endtask

  initial begin
    reset = 1'b1; domain = 1'b0; req_issue = 1'b0; squash = 1'b0;
    in_resp_val = 1'b0; out_resp_rdy = 1'b1; in_resp_msg = '0;
    @(posedge clk); #1;
    do_reset();

    // Three in flight, squash, three dropped, fourth passes through
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t31_num_out", {29'b0, num_out}, 32'd3);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t31_num_out_end", {29'b0, num_out}, 32'd0);

    // Issue in the squash cycle survives
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("t32_num_out", {29'b0, num_out}, 32'd3);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t32_num_out_end", {29'b0, num_out}, 32'd0);

    // Response accepted in the squash cycle is delivered
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t33_num_out", {29'b0, num_out}, 32'd1);
    check_eq("t33_drop_state", {31'b0, out_resp_val}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t33_num_out_end", {29'b0, num_out}, 32'd0);

    // Full: req_rdy low, illegal issue ignored, one response restores it
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t34_req_rdy_full", {31'b0, req_rdy}, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t34_num_out_full", {29'b0, num_out}, 32'd4);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t34_req_rdy_back", {31'b0, req_rdy}, 32'd1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a drop
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t35_num_out", {29'b0, num_out}, 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic iss, sq, rv, ordy;
      iss  = ($urandom_range(0, 1) == 1);
      sq   = ($urandom_range(0, 9) == 0);
      rv   = (mO > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(iss, sq, rv, ordy);
    end
    repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycle();

`ifdef VC_DROP_UNIT_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    end
    check_eq("t36_num_dropped", {16'b0, num_dropped}, 32'd10);
`endif

    check_eq("sb_left", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
